// File: rtl/rv_pkg.sv
// Shared types for the root-voter cell and its host-side controller.
// Vote-type encoding and active-slot decoding must match the voter cell.
package rv_pkg;

  localparam int unsigned NUM_SLOTS = 9;
  localparam int unsigned RES_W     = 8;
  localparam int unsigned STATUS_W  = 14;

  typedef enum logic [1:0] {
    V2OO2 = 2'b00,
    V2OO3 = 2'b01,
    V4OO7 = 2'b10,
    V5OO9 = 2'b11
  } vote_type_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_CAPTURE,
    S_RELEASE,
    S_DONE
  } state_t;

  function automatic logic [3:0] active_slots(input vote_type_t vt);
    logic [3:0] n;
    n = 4'd2;
    case (vt)
      V2OO2: n = 4'd2;
      V2OO3: n = 4'd3;
      V4OO7: n = 4'd7;
      V5OO9: n = 4'd9;
      default: n = 4'd2;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/rv_cell_ctrl.sv
// Host-side driver for one root-voter cell: arms it, loads datasets, waits for
// ready, captures results, then releases the cell and reports done.
module rv_cell_ctrl
  import rv_pkg::*;
#(
  parameter int unsigned REG_DATA_WIDTH = 64,
  parameter int unsigned MAX_DATASETS   = 9,
  parameter int unsigned GUARD_W        = 16
) (
  input  logic                                   clk,
  input  logic                                   rstn,
  input  logic                                   start,
  input  logic                                   abort,
  input  logic [1:0]                             vote_type,
  input  logic [29:0]                            timeout_cycles,
  input  logic                                   wr_en,
  input  logic [3:0]                             wr_idx,
  input  logic [REG_DATA_WIDTH-1:0]              wr_data,
  output logic [31:0]                            cell_cfg,
  output logic [MAX_DATASETS*REG_DATA_WIDTH-1:0] cell_set,
  output logic [MAX_DATASETS-1:0]                cell_valid,
  input  logic [MAX_DATASETS*8-1:0]              cell_res,
  input  logic [13:0]                            cell_status,
  output logic                                   busy,
  output logic                                   done,
  output logic [MAX_DATASETS*8-1:0]              res_q,
  output logic [MAX_DATASETS-1:0]                miss_q,
  output logic [3:0]                             err_q
);

  state_t             state;
  vote_type_t         vt_q;
  logic [GUARD_W-1:0] guard;
  logic [3:0]         act;
  logic [MAX_DATASETS-1:0] wr_hit;
  logic               ready;
  logic               guard_max;
  logic               status_unused;

  assign ready         = cell_status[0];
  assign guard_max     = &guard;
  assign status_unused = ^cell_status[13:10];

  always_comb begin
    act = active_slots(vt_q);
  end

  for (genvar k = 0; k < MAX_DATASETS; k++) begin : g_slot
    assign wr_hit[k] = wr_en && (wr_idx == 4'(k)) && (4'(k) < act);
  end

  // Slot writes are evaluated before the state case so that a write landing in
  // the same cycle as ready is kept, while a move to RELEASE still clears valid.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= S_IDLE;
      vt_q       <= V2OO2;
      guard      <= '0;
      cell_cfg   <= '0;
      cell_set   <= '0;
      cell_valid <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      res_q      <= '0;
      miss_q     <= '0;
      err_q      <= '0;
    end else begin
      if (state == S_ARMED) begin
        for (int unsigned k = 0; k < MAX_DATASETS; k++) begin
          if (wr_hit[k]) begin
            if (cell_valid[k]) begin
              err_q[1] <= 1'b1;
            end else begin
              cell_set[k*REG_DATA_WIDTH +: REG_DATA_WIDTH] <= wr_data;
              cell_valid[k] <= 1'b1;
            end
          end
        end
      end

      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            vt_q       <= vote_type_t'(vote_type);
            cell_valid <= '0;
            guard      <= '0;
            if ({timeout_cycles, vote_type} == '0) begin
              err_q <= 4'b0001;
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              err_q    <= '0;
              cell_cfg <= {timeout_cycles, vote_type};
              busy     <= 1'b1;
              state    <= S_ARMED;
            end
          end
        end

        S_ARMED: begin
          if (abort || guard_max) begin
            if (abort) err_q[2] <= 1'b1;
            else       err_q[3] <= 1'b1;
            cell_cfg   <= '0;
            cell_valid <= '0;
            guard      <= '0;
            state      <= S_RELEASE;
          end else if (ready) begin
            state <= S_CAPTURE;
          end else begin
            guard <= guard + GUARD_W'(1);
          end
        end

        S_CAPTURE: begin
          res_q      <= cell_res;
          miss_q     <= cell_status[9:1];
          cell_cfg   <= '0;
          cell_valid <= '0;
          guard      <= '0;
          state      <= S_RELEASE;
        end

        S_RELEASE: begin
          if (!ready || guard_max) begin
            if (ready) err_q[3] <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            guard <= guard + GUARD_W'(1);
          end
        end

        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
